m68k_irq_sched: RTL and testbench

// - Interrupt scheduler for the m68k Wishbone SoC: synchronises 7 interrupt request lines, latches them (level/edge per line),

---
 rtl/m68k_irq_sched_pkg.sv | 34 +++
 rtl/m68k_irq_sched_prio_enc.sv | 28 ++
 rtl/m68k_irq_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_m68k_irq_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_irq_sched_pkg.sv
// m68k_irq_pkg: shared definitions for the m68k interrupt scheduler.
// - Register map (2-bit Wishbone addresses).
// - IACK state machine encoding.
// - Level width constants.
// - Helper that turns a level number into a one-hot pending-bit mask.
package m68k_irq_pkg;

  localparam int NUM_LEVELS = 7;
  localparam int LEVEL_W    = 3;

  localparam logic [1:0] ADR_PEND = 2'd0;
  localparam logic [1:0] ADR_MASK = 2'd1;
  localparam logic [1:0] ADR_EDGE = 2'd2;
  localparam logic [1:0] ADR_VCFG = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_ACK     = 2'd2,
    ST_WAIT    = 2'd3
  } iack_state_e;

  // Level n (1..7) maps to pending bit n-1; level 0 selects no bit.
  function automatic logic [NUM_LEVELS-1:0] level_onehot(input logic [LEVEL_W-1:0] level);
    logic [NUM_LEVELS-1:0] mask;
    if (level == 3'd0) begin
      mask = 7'h00;
    end else begin
      mask = 7'h01 << (level - 3'd1);
    end
    return mask;
  endfunction

endpackage

// File: rtl/m68k_irq_sched_prio_enc.sv
// irq_prio_enc: highest-set-bit encoder for the interrupt priority code.
// Ports:
//   req   in  7  enabled pending requests, bit n = level n+1
//   level out 3  highest requesting level, 0 when req is empty
module irq_prio_enc
  import m68k_irq_pkg::*;
(
  input  logic [NUM_LEVELS-1:0] req,
  input  logic                  unused_tie,
  output logic [LEVEL_W-1:0]    level
);

  // Scan upwards so the highest set bit overwrites lower ones.
  always_comb begin
    level = 3'd0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (req[i]) begin
        level = 3'(i + 1);
      end else begin
        level = level;
      end
    end
  end

  logic unused_s;
  assign unused_s = unused_tie;

endmodule

// File: rtl/m68k_irq_sched.sv
// m68k_irq_sched: interrupt scheduler between peripheral IRQ lines and the
// 68000 IPL/IACK pins, configured over an 8-bit Wishbone slave.
// Ports:
//   wb_clk_i, wb_reset_i          clock, synchronous active-high reset
//   int_i[6:0]                    async requests, bit n = level n+1
//   wb_cyc_i/stb_i/we_i/adr_i/dat_i, wb_dat_o/ack_o   Wishbone slave
//   ipl_o[2:0]                    registered priority code, 0 = none
//   iack_i, iack_level_i[2:0]     CPU interrupt-acknowledge request
//   iack_ack_o, vector_o, avec_o  one-cycle IACK response
module m68k_irq_sched
  import m68k_irq_pkg::*;
#(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [6:0]  MASK_RST     = 7'h00,
  parameter logic [7:0]  VCFG_RST     = 8'h41,
  parameter logic [7:0]  SPURIOUS_VEC = 8'h18
) (
  input  logic       wb_clk_i,
  input  logic       wb_reset_i,
  input  logic [6:0] int_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic [2:0] ipl_o,
  input  logic       iack_i,
  input  logic [2:0] iack_level_i,
  output logic       iack_ack_o,
  output logic [7:0] vector_o,
  output logic       avec_o
);

  logic [NUM_LEVELS-1:0] sync_r [SYNC_STAGES];
  logic [NUM_LEVELS-1:0] prev_r;
  logic [NUM_LEVELS-1:0] pend_r, mask_r, edge_r;
  logic [7:0]            vcfg_r;
  iack_state_e           state_r;

  logic [NUM_LEVELS-1:0] synced_s, rise_s, enabled_s, w1c_s, iack_clr_s, pend_nxt_s;
  logic [LEVEL_W-1:0]    top_level_s;
  logic                  req_s, wr_s, iack_hit_s;
  logic [7:0]            rdata_s;

  assign synced_s  = sync_r[SYNC_STAGES-1];
  assign rise_s    = synced_s & ~prev_r;
  assign enabled_s = pend_r & mask_r;
  assign req_s     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_s      = req_s & wb_we_i;

  // Input synchroniser plus one extra stage used for rising-edge detection.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= 7'h00;
      end
      prev_r <= 7'h00;
    end else begin
      sync_r[0] <= int_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= synced_s;
    end
  end

  // Clear sources for edge-mode bits: software W1C and the IACK of that level.
  always_comb begin
    w1c_s      = 7'h00;
    iack_hit_s = 1'b0;
    iack_clr_s = 7'h00;
    if (wr_s && (wb_adr_i == ADR_PEND)) begin
      w1c_s = wb_dat_i[6:0];
    end else begin
      w1c_s = 7'h00;
    end
    if (state_r == ST_RESOLVE) begin
      iack_hit_s = |(enabled_s & level_onehot(iack_level_i));
    end else begin
      iack_hit_s = 1'b0;
    end
    if (iack_hit_s) begin
      iack_clr_s = level_onehot(iack_level_i);
    end else begin
      iack_clr_s = 7'h00;
    end
  end

  // Next pending value: level bits mirror the input, edge bits latch with set priority.
  always_comb begin
    pend_nxt_s = pend_r;
    for (int n = 0; n < NUM_LEVELS; n++) begin
      if (edge_r[n]) begin
        pend_nxt_s[n] = rise_s[n] | (pend_r[n] & ~(w1c_s[n] | iack_clr_s[n]));
      end else begin
        pend_nxt_s[n] = synced_s[n];
      end
    end
  end

  // Pending register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      pend_r <= 7'h00;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Software-writable configuration registers; writes land on the ack edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      mask_r <= MASK_RST;
      edge_r <= 7'h00;
      vcfg_r <= VCFG_RST & 8'hF9;
    end else if (wr_s) begin
      case (wb_adr_i)
        ADR_MASK: mask_r <= wb_dat_i[6:0];
        ADR_EDGE: edge_r <= wb_dat_i[6:0];
        ADR_VCFG: vcfg_r <= {wb_dat_i[7:3], 2'b00, wb_dat_i[0]};
        default:  mask_r <= mask_r;
      endcase
    end else begin
      mask_r <= mask_r;
    end
  end

  // Read mux; unimplemented bits read as zero.
  always_comb begin
    rdata_s = 8'h00;
    case (wb_adr_i)
      ADR_PEND: rdata_s = {1'b0, pend_r};
      ADR_MASK: rdata_s = {1'b0, mask_r};
      ADR_EDGE: rdata_s = {1'b0, edge_r};
      ADR_VCFG: rdata_s = vcfg_r;
      default:  rdata_s = 8'h00;
    endcase
  end

  // Wishbone handshake: single-cycle ack, data valid only alongside ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
    end else if (req_s) begin
      wb_ack_o <= 1'b1;
      wb_dat_o <= rdata_s;
    end else begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
    end
  end

  irq_prio_enc u_prio (
    .req        (enabled_s),
    .unused_tie (1'b0),
    .level      (top_level_s)
  );

  // Registered priority code to the CPU.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      ipl_o <= 3'd0;
    end else begin
      ipl_o <= top_level_s;
    end
  end

  // IACK state machine: resolve the level one cycle after the request,
  // pulse the response, then wait for the CPU to end its cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      state_r    <= ST_IDLE;
      iack_ack_o <= 1'b0;
      vector_o   <= 8'h00;
      avec_o     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          iack_ack_o <= 1'b0;
          if (iack_i) begin
            state_r <= ST_RESOLVE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RESOLVE: begin
          iack_ack_o <= 1'b1;
          state_r    <= ST_ACK;
          if (iack_hit_s) begin
            vector_o <= {vcfg_r[7:3], iack_level_i};
            avec_o   <= vcfg_r[0];
          end else begin
            vector_o <= SPURIOUS_VEC;
            avec_o   <= 1'b0;
          end
        end
        ST_ACK: begin
          iack_ack_o <= 1'b0;
          vector_o   <= 8'h00;
          avec_o     <= 1'b0;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          iack_ack_o <= 1'b0;
          if (iack_i) begin
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          iack_ack_o <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_irq_sched.sv
// Self-checking bench for m68k_irq_sched: directed scenarios plus randomized
// IRQ traffic compared against a delay-line reference model.
module tb_m68k_irq_sched;

  localparam int S = 2;
  localparam logic [6:0] MASK_RST_TB = 7'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] irq;
  logic       cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] wdat;
  logic [7:0] rdat;
  logic       wack;
  logic [2:0] ipl;
  logic       iack;
  logic [2:0] iack_lvl;
  logic       iack_ack;
  logic [7:0] vec;
  logic       avec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m68k_irq_sched #(.SYNC_STAGES(S), .MASK_RST(MASK_RST_TB), .VCFG_RST(8'h41), .SPURIOUS_VEC(8'h18)) dut (
    .wb_clk_i(clk), .wb_reset_i(rst), .int_i(irq),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(rdat), .wb_ack_o(wack), .ipl_o(ipl),
    .iack_i(iack), .iack_level_i(iack_lvl), .iack_ack_o(iack_ack),
    .vector_o(vec), .avec_o(avec)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One Wishbone transfer with a bounded wait for ack.
  task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] d, output logic [7:0] q);
    bit got = 1'b0;
    q = 8'h00;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (wack === 1'b1) begin
        got = 1'b1;
        q = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wb_ack: no ack for adr=%0d", a);
    end
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [7:0] q);
    wb_xfer(1'b0, a, 8'h00, q);
  endtask

  // Reference: highest set level of a 7-bit request set.
  function automatic logic [2:0] top_level(input logic [6:0] bits);
    for (int l = 7; l >= 1; l--) begin
      if (bits[l-1]) return 3'(l);
    end
    return 3'd0;
  endfunction

  task automatic test_reset();
    logic [7:0] q;
    logic [7:0] exp [4];
    exp[0] = 8'h00; exp[1] = {1'b0, MASK_RST_TB}; exp[2] = 8'h00; exp[3] = 8'h41;
    rst = 1'b1; irq = 7'h00; iack = 1'b0; iack_lvl = 3'd0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'd0; wdat = 8'h00;
    repeat (3) tick();
    checks++;
    if ({ipl, iack_ack, wack, vec, avec, rdat} !== 22'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ipl=%0d ack=%b wack=%b vec=%h avec=%b dat=%h, expected all 0",
               ipl, iack_ack, wack, vec, avec, rdat);
    end
    rst = 1'b0;
    tick();
    for (int r = 0; r < 4; r++) begin
      wb_read(2'(r), q);
      checks++;
      if (q !== exp[r]) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected %h", r, q, exp[r]);
      end
    end
  endtask

  task automatic test_level();
    wb_write(2'd1, 8'h7F);
    irq = 7'h05;
    repeat (S + 1) tick();
    checks++;
    if (ipl !== 3'd0) begin
      errors++; $display("FAIL level_early: got ipl=%0d expected 0", ipl);
    end
    tick();
    checks++;
    if (ipl !== 3'd3) begin
      errors++; $display("FAIL level_05: got ipl=%0d expected 3", ipl);
    end
    irq = 7'h45;
    repeat (S + 2) tick();
    checks++;
    if (ipl !== 3'd7) begin
      errors++; $display("FAIL level_45: got ipl=%0d expected 7", ipl);
    end
    irq = 7'h00;
    repeat (S + 2) tick();
    checks++;
    if (ipl !== 3'd0) begin
      errors++; $display("FAIL level_00: got ipl=%0d expected 0", ipl);
    end
  endtask

  task automatic test_edge();
    logic [7:0] q;
    wb_write(2'd2, 8'h08);
    irq = 7'h08; tick(); irq = 7'h00;
    repeat (6) tick();
    wb_read(2'd0, q);
    checks++;
    if (q !== 8'h08 || ipl !== 3'd4) begin
      errors++; $display("FAIL edge_latch: got pend=%h ipl=%0d expected pend=08 ipl=4", q, ipl);
    end
    wb_write(2'd0, 8'h08);
    tick();
    checks++;
    if (ipl !== 3'd0) begin
      errors++; $display("FAIL edge_w1c_ipl: got ipl=%0d expected 0", ipl);
    end
    wb_read(2'd0, q);
    checks++;
    if (q !== 8'h00) begin
      errors++; $display("FAIL edge_w1c_pend: got %h expected 00", q);
    end
  endtask

  task automatic test_iack();
    logic [7:0] q;
    logic [4:0] base;
    logic [2:0] lv;
    wb_write(2'd3, 8'h60);
    wb_write(2'd2, 8'h10);
    irq = 7'h10; tick(); irq = 7'h00;
    repeat (6) tick();
    checks++;
    if (ipl !== 3'd5) begin
      errors++; $display("FAIL iack_pre_ipl: got %0d expected 5", ipl);
    end
    iack = 1'b1; iack_lvl = 3'd5;
    tick();
    checks++;
    if (iack_ack !== 1'b0) begin
      errors++; $display("FAIL iack_latency: got ack=%b one cycle after request, expected 0", iack_ack);
    end
    tick();
    checks++;
    if (iack_ack !== 1'b1 || vec !== 8'h65 || avec !== 1'b0) begin
      errors++; $display("FAIL iack_vec: got ack=%b vec=%h avec=%b expected 1/65/0", iack_ack, vec, avec);
    end
    tick();
    checks++;
    if (iack_ack !== 1'b0) begin
      errors++; $display("FAIL iack_pulse: got ack=%b expected 0", iack_ack);
    end
    iack = 1'b0;
    tick();
    wb_read(2'd0, q);
    checks++;
    if (q !== 8'h00 || ipl !== 3'd0) begin
      errors++; $display("FAIL iack_clear: got pend=%h ipl=%0d expected 00/0", q, ipl);
    end
    // Autovector path with a random base and level, level-mode line.
    base = 5'($urandom_range(0, 31));
    lv   = 3'($urandom_range(1, 7));
    wb_write(2'd3, {base, 3'b111});
    wb_read(2'd3, q);
    checks++;
    if (q !== {base, 3'b001}) begin
      errors++; $display("FAIL vcfg_rw: got %h expected %h", q, {base, 3'b001});
    end
    wb_write(2'd2, 8'h00);
    irq = 7'h01 << (lv - 3'd1);
    repeat (5) tick();
    iack = 1'b1; iack_lvl = lv;
    tick(); tick();
    checks++;
    if (iack_ack !== 1'b1 || vec !== {base, lv} || avec !== 1'b1) begin
      errors++; $display("FAIL iack_avec: got ack=%b vec=%h avec=%b expected 1/%h/1", iack_ack, vec, avec, {base, lv});
    end
    iack = 1'b0; irq = 7'h00;
    repeat (4) tick();
  endtask

  task automatic test_spurious();
    int acks = 0;
    logic [7:0] v = 8'h00;
    logic a = 1'b1;
    wb_write(2'd1, 8'h7D);
    irq = 7'h02;
    repeat (5) tick();
    checks++;
    if (ipl !== 3'd0) begin
      errors++; $display("FAIL masked_ipl: got %0d expected 0", ipl);
    end
    iack = 1'b1; iack_lvl = 3'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (iack_ack === 1'b1) begin acks++; v = vec; a = avec; end
    end
    iack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (iack_ack === 1'b1) begin acks++; v = vec; a = avec; end
    end
    checks++;
    if (acks != 1 || v !== 8'h18 || a !== 1'b0) begin
      errors++; $display("FAIL spurious_masked: got acks=%0d vec=%h avec=%b expected 1/18/0", acks, v, a);
    end
    wb_write(2'd1, 8'h7F);
    iack = 1'b1; iack_lvl = 3'd0;
    tick(); tick();
    checks++;
    if (iack_ack !== 1'b1 || vec !== 8'h18 || avec !== 1'b0) begin
      errors++; $display("FAIL spurious_lvl0: got ack=%b vec=%h avec=%b expected 1/18/0", iack_ack, vec, avec);
    end
    iack = 1'b0; irq = 7'h00;
    repeat (4) tick();
  endtask

  task automatic test_collision();
    logic [7:0] q;
    wb_write(2'd2, 8'h04);
    irq = 7'h04; tick(); irq = 7'h00;
    repeat (6) tick();
    wb_read(2'd0, q);
    checks++;
    if (q !== 8'h04) begin
      errors++; $display("FAIL collision_pre: got %h expected 04", q);
    end
    // New rising edge reaches the pending logic on the same edge as the W1C.
    irq = 7'h04;
    repeat (S) tick();
    wb_write(2'd0, 8'h04);
    wb_read(2'd0, q);
    checks++;
    if (q !== 8'h04) begin
      errors++; $display("FAIL collision_setwins: got %h expected 04", q);
    end
    irq = 7'h00;
    repeat (4) tick();
    wb_write(2'd0, 8'h04);
    wb_read(2'd0, q);
    checks++;
    if (q !== 8'h00) begin
      errors++; $display("FAIL collision_w1c: got %h expected 00", q);
    end
  endtask

  task automatic test_reset_mid_iack();
    int acks = 0;
    logic [7:0] q;
    iack = 1'b1; iack_lvl = 3'd3;
    tick();
    rst = 1'b1; iack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (iack_ack === 1'b1) acks++;
      if (i == 1) rst = 1'b0;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL reset_iack: got %0d ack pulses expected 0", acks);
    end
    wb_read(2'd1, q);
    checks++;
    if (q !== {1'b0, MASK_RST_TB}) begin
      errors++; $display("FAIL reset_iack_mask: got %h expected %h", q, {1'b0, MASK_RST_TB});
    end
    iack = 1'b1; iack_lvl = 3'd1;
    tick(); tick();
    checks++;
    if (iack_ack !== 1'b1 || vec !== 8'h18) begin
      errors++; $display("FAIL reset_iack_reissue: got ack=%b vec=%h expected 1/18", iack_ack, vec);
    end
    iack = 1'b0;
    repeat (3) tick();
  endtask

  // Random IRQ traffic against a model: pending bits derive from the input
  // value seen S edges earlier; ipl lags pending by one cycle.
  task automatic test_random();
    logic [6:0] m_mask, m_edge, m_pend, nxt, syn, prv, cur;
    logic [2:0] m_ipl;
    logic [7:0] q;
    logic [6:0] hist [$];
    for (int r = 0; r < 4; r++) begin
      m_mask = 7'($urandom); m_edge = 7'($urandom);
      irq = 7'h00;
      wb_write(2'd1, {1'b0, m_mask});
      wb_write(2'd2, {1'b0, m_edge});
      repeat (4) tick();
      wb_write(2'd0, 8'h7F);
      repeat (4) tick();
      m_pend = 7'h00; m_ipl = 3'd0;
      hist.delete();
      for (int i = 0; i < S + 2; i++) hist.push_back(7'h00);
      for (int c = 0; c < 90; c++) begin
        if (c < 80 && $urandom_range(0, 3) == 0) irq = irq ^ 7'(7'h01 << $urandom_range(0, 6));
        cur = irq;
        tick();
        hist.push_front(cur);
        syn = hist[S]; prv = hist[S+1];
        void'(hist.pop_back());
        for (int n = 0; n < 7; n++) begin
          nxt[n] = m_edge[n] ? (m_pend[n] | (syn[n] & ~prv[n])) : syn[n];
        end
        m_ipl = top_level(m_pend & m_mask);
        m_pend = nxt;
        checks++;
        if (ipl !== m_ipl) begin
          errors++;
          $display("FAIL rand_ipl: round %0d cycle %0d got %0d expected %0d", r, c, ipl, m_ipl);
        end
      end
      wb_read(2'd0, q);
      checks++;
      if (q !== {1'b0, m_pend}) begin
        errors++; $display("FAIL rand_pend: round %0d got %h expected %h", r, q, {1'b0, m_pend});
      end
    end
    irq = 7'h00;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_iack();
    test_spurious();
    test_collision();
    test_reset_mid_iack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
